// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Booth pair {q0, q-1}: 01 adds the multiplicand, 10 subtracts it, others shift only
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH+1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  // Partial remainder stays within (-divisor, divisor), so the top bit can be dropped on shift
  always_comb begin
    shifted  = {rem[WIDTH:0], quo[WIDTH-1]};
    dvs_ext  = {2'b00, divisor};
    rem_next = rem[WIDTH+1] ? shifted + dvs_ext : shifted - dvs_ext;
    quo_next = {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit with fixed latency.
// Optional signed-overflow flagging is enabled with `define MULTDIV_OVERFLOW_EN.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_mul;
  logic [2*WIDTH:0] prod;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             div_zero;
  logic             div_exc;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH+1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_exc_in;
  logic             mul_exc;

  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_OVERFLOW_EN
  assign div_exc_in = ~|data_operandB ||
                      (data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB);
  assign mul_exc    = !(&prod[2*WIDTH:WIDTH] || ~|prod[2*WIDTH:WIDTH]);
`else
  assign div_exc_in = ~|data_operandB;
  assign mul_exc    = 1'b0;
`endif

  // Accumulator is extended by one bit so subtracting the most-negative multiplicand cannot overflow
  always_comb begin
    booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    case (prod[1:0])
      BOOTH_ADD: booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
      BOOTH_SUB: booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
      default:   booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // A start pulse always wins, so it restarts any operation in flight without an RDY pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state          <= IDLE;
      count          <= '0;
      is_mul         <= 1'b0;
      prod           <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_exc        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        state    <= ctrl_MULT ? MUL : DIV;
        is_mul   <= ctrl_MULT;
        count    <= '0;
        busy     <= 1'b1;
        prod     <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        mcand    <= data_operandA;
        rem      <= '0;
        quo      <= a_mag;
        dvsr     <= b_mag;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= ~|data_operandB;
        div_exc  <= div_exc_in;
      end else begin
        case (state)
          MUL: begin
            prod  <= {booth_sum, prod[WIDTH:1]};
            count <= count + 1'b1;
            if (count == LAST) state <= DONE;
          end
          DIV: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST) state <= DONE;
          end
          DONE: begin
            if (is_mul) begin
              data_result    <= prod[WIDTH:1];
              data_exception <= mul_exc;
            end else begin
              data_result    <= div_zero ? '0 : (neg_q ? -quo : quo);
              data_exception <= div_exc;
            end
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit in the execute stage. It accepts a one-cycle start pulse from the decode/execute control, computes over a fixed number of cycles, and presents a registered result with a one-cycle ready strobe. The X/M pipeline latch (falling-edge enabled flops) consumes the result. The hazard logic stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset, asynchronous, active-low.
- `ctrl_MULT`  in  1  start-multiply pulse, sampled on rising edge.
- `ctrl_DIV`  in  1  start-divide pulse, sampled on rising edge.
- `data_operandA`  in  WIDTH  multiplicand / dividend (two's complement); sampled only on a start edge.
- `data_operandB`  in  WIDTH  multiplier / divisor (two's complement); sampled only on a start edge.
- `data_result`  out  WIDTH  product low word or quotient; held until the next start.
- `data_exception`  out  1  error flag, valid with and held alongside `data_result`.
- `data_resultRDY`  out  1  high for exactly one cycle when the result is valid.
- `busy`  out  1  high while an operation is in progress.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start edge (`ctrl_MULT` or `ctrl_DIV` high):
  - Latch the operands.
  - Clear the iteration counter.
  - Go to MUL or DIV.
- If both starts are high on the same edge, MULT wins and DIV is ignored.
- A start while in MUL, DIV or DONE aborts the current operation and restarts with the new operands. No RDY pulse is issued for the aborted operation.
- MUL uses radix-2 Booth over a 2·WIDTH+1 product register, one step per cycle, for WIDTH cycles.
  - `data_result` = product[WIDTH-1:0].
- DIV uses non-restoring division on operand magnitudes, one step per cycle, for WIDTH cycles.
  - The quotient is negated if the operand signs differ (truncation toward zero).
  - The remainder is discarded.
- Divide by zero (B == 0): `data_result` = 0 and `data_exception` = 1. The unit still runs the full latency so that timing stays fixed.
- DONE lasts one cycle:
  - Register the result and exception.
  - Assert `data_resultRDY`.
  - Return to IDLE.
- The counter is log2(WIDTH)+1 bits wide and exits at count == WIDTH-1. It never wraps mid-operation.
- Reset (`clr` low, any time including mid-operation):
  - State goes to IDLE.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
  - Counter and internal registers are cleared.

## Timing
- Latency is fixed at WIDTH+1 rising edges after the start edge, for both operations.
  - The start edge is edge 0.
  - `data_resultRDY` is high between edge WIDTH+1 and edge WIDTH+2.
- `busy` rises on the start edge. It falls on the edge where `data_resultRDY` rises.
- `data_result` and `data_exception` change only on the RDY edge or on reset. They are stable for the downstream falling-edge capture.
- Back-to-back operation: a start may be given in the same cycle that RDY is high. That start is accepted and the RDY pulse still completes.
- All outputs are registered. No combinational path exists from the inputs to the outputs.

## Configuration
- `MULTDIV_OVERFLOW_EN` defined:
  - MUL sets `data_exception` when product[2·WIDTH-1:WIDTH-1] are not all equal (signed overflow).
  - DIV sets `data_exception` for the most-negative value / −1. The result is 0x80000000.
- Not defined:
  - `data_exception` is asserted only for divide by zero.
  - Overflowing products return the low word with no flag.
  - Most-negative / −1 returns 0x80000000 with no flag.

## Structure
- Package `multdiv_pkg`:
  - State enum (IDLE/MUL/DIV/DONE).
  - Default `WIDTH`.
  - Booth select encoding constants.
  - Counter width function.
- Sub-module `div_step`: combinational single non-restoring iteration, taking remainder, quotient and divisor and producing the next remainder and quotient.
  - The DIV datapath instantiates it once.
  - The Booth step stays inline.

## Test plan
- 7 × −3 → RDY at edge 33, result 0xFFFFFFEB (−21), exception 0.
- −100 / 7 → result 0xFFFFFFF2 (−14), exception 0, latency 33.
- 5 / 0 → result 0, exception 1, RDY at edge 33.
- 0x00010000 × 0x00010000:
  - With `MULTDIV_OVERFLOW_EN` → result 0, exception 1.
  - Without the macro → result 0, exception 0.
- Abort: start MULT 3×4, then start DIV 20/4 at edge 10 → a single RDY at edge 43, result 5; no RDY at edge 33.
- `clr` low at edge 15 of a multiply → all outputs 0 immediately and `busy` 0. A new start after release yields the correct result with full latency.
